// File: rtl/des_pkg.sv
// Shared definitions for the DES buffer controller: APB mode encodings,
// FIFO sizing defaults, key-load states and the input FIFO payload.
package des_pkg;

  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BLK_W     = 64;
  localparam int unsigned CNT_W     = 4;

  localparam logic [2:0] MODE_IDLE     = 3'd0;
  localparam logic [2:0] MODE_WR_ENC   = 3'd1;
  localparam logic [2:0] MODE_WR_DEC   = 3'd2;
  localparam logic [2:0] MODE_KEY1     = 3'd3;
  localparam logic [2:0] MODE_KEY2     = 3'd4;
  localparam logic [2:0] MODE_SOFT_RST = 3'd5;
  localparam logic [2:0] MODE_RD_POP   = 3'd6;

  typedef enum logic [2:0] {
    K1_HI,
    K1_LO,
    K2_HI,
    K2_LO,
    DONE
  } key_state_t;

  typedef struct packed {
    logic              decrypt;
    logic [WORD_W-1:0] word;
  } in_word_t;

endpackage

// File: rtl/word_fifo.sv
// Circular word FIFO that accepts 0-2 pushes and 0-2 pops per cycle and
// exposes its two oldest entries; callers guarantee no overflow/underflow.
module word_fifo
  import des_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       push_n,
  input  logic [WIDTH-1:0] push_d0,
  input  logic [WIDTH-1:0] push_d1,
  input  logic [1:0]       pop_n,
  output logic [WIDTH-1:0] head0,
  output logic [WIDTH-1:0] head1,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SUM_W = PTR_W + 2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Advance a pointer by 0-2 slots, wrapping at DEPTH (not necessarily a power of two).
  function automatic logic [PTR_W-1:0] adv(input logic [PTR_W-1:0] p, input logic [1:0] n);
    logic [SUM_W-1:0] s;
    s = SUM_W'(p) + SUM_W'(n);
    if (s >= SUM_W'(DEPTH)) begin
      s = s - SUM_W'(DEPTH);
    end
    return PTR_W'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= adv(wr_ptr, push_n);
      rd_ptr <= adv(rd_ptr, pop_n);
      count  <= count + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      if (push_n != 2'd0) begin
        mem[wr_ptr] <= push_d0;
      end
      if (push_n == 2'd2) begin
        mem[adv(wr_ptr, 2'd1)] <= push_d1;
      end
    end
  end

  assign head0 = mem[rd_ptr];
  assign head1 = mem[adv(rd_ptr, 2'd1)];

endmodule

// File: rtl/des_buffer_ctrl.sv
// Buffers APB words into 64-bit blocks for a 3DES core, collects its results
// into a word FIFO for readback, and sequences the two-key load.
module des_buffer_ctrl
  import des_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          mode,
  input  logic [WORD_W-1:0]   pwdata,
  output logic [CNT_W-1:0]    data_in_cnt,
  output logic [CNT_W-1:0]    data_out_cnt,
  output logic [WORD_W-1:0]   data_out,
  output logic                blk_valid,
  input  logic                blk_ready,
  output logic [BLK_W-1:0]    blk_data,
  output logic                blk_decrypt,
  output logic [BLK_W-1:0]    key1,
  output logic [BLK_W-1:0]    key2,
  output logic                key_valid,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic [BLK_W-1:0]    res_data
);

  localparam int unsigned IN_W = $bits(in_word_t);

  logic              soft_clr;
  logic              fifo_clr;
  logic              wr_cmd;
  logic              in_push;
  logic              in_pop;
  in_word_t          in_wr;
  in_word_t          in_head0;
  in_word_t          in_head1;
  logic              rd_req;
  logic              out_pop;
  logic              out_push;
  logic [CNT_W-1:0]  out_level;
  logic [WORD_W-1:0] out_head0;
  logic [WORD_W-1:0] out_head1_unused;

  key_state_t        key_state;
  key_state_t        key_state_nx;
  logic [BLK_W-1:0]  key1_nx;
  logic [BLK_W-1:0]  key2_nx;
  logic              key_valid_nx;

  assign soft_clr = (mode == MODE_SOFT_RST);
  assign fifo_clr = rst || soft_clr;

  // Input side: direction-tagged words, drained two at a time into the core.
  assign wr_cmd   = (mode == MODE_WR_ENC) || (mode == MODE_WR_DEC);
  assign in_push  = !fifo_clr && wr_cmd && (data_in_cnt < CNT_W'(DEPTH));
  assign in_wr    = '{decrypt: (mode == MODE_WR_DEC), word: pwdata};

  assign blk_valid   = !rst && key_valid && (data_in_cnt >= CNT_W'(2));
  assign in_pop      = blk_valid && blk_ready;
  assign blk_data    = {in_head0.word, in_head1.word};
  assign blk_decrypt = in_head0.decrypt;

  word_fifo #(
    .WIDTH (IN_W),
    .DEPTH (DEPTH)
  ) u_in_fifo (
    .clk     (clk),
    .clr     (fifo_clr),
    .push_n  ({1'b0, in_push}),
    .push_d0 (in_wr),
    .push_d1 (in_wr),
    .pop_n   (in_pop ? 2'd2 : 2'd0),
    .head0   (in_head0),
    .head1   (in_head1),
    .count   (data_in_cnt)
  );

  // Output side: a result needs two free slots after any same-cycle read.
  assign rd_req    = (mode == MODE_RD_POP) && (data_out_cnt != '0);
  assign out_pop   = !fifo_clr && rd_req;
  assign out_level = data_out_cnt - CNT_W'(rd_req);
  assign res_ready = rst || (out_level <= CNT_W'(DEPTH - 2));
  assign out_push  = !fifo_clr && res_valid && res_ready;
  assign data_out  = (rst || (data_out_cnt == '0)) ? '0 : out_head0;

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .clr     (fifo_clr),
    .push_n  (out_push ? 2'd2 : 2'd0),
    .push_d0 (res_data[BLK_W-1:WORD_W]),
    .push_d1 (res_data[WORD_W-1:0]),
    .pop_n   ({1'b0, out_pop}),
    .head0   (out_head0),
    .head1   (out_head1_unused),
    .count   (data_out_cnt)
  );

  // Key-load state and key registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_state <= K1_HI;
      key1      <= '0;
      key2      <= '0;
      key_valid <= 1'b0;
    end else begin
      key_state <= key_state_nx;
      key1      <= key1_nx;
      key2      <= key2_nx;
      key_valid <= key_valid_nx;
    end
  end

  // Key words must arrive as key1 hi/lo then key2 hi/lo; stray commands are ignored.
  always_comb begin
    key_state_nx = key_state;
    key1_nx      = key1;
    key2_nx      = key2;
    key_valid_nx = key_valid;
    if (soft_clr) begin
      key_state_nx = K1_HI;
      key1_nx      = '0;
      key2_nx      = '0;
      key_valid_nx = 1'b0;
    end else begin
      case (key_state)
        K1_HI, DONE: begin
          if (mode == MODE_KEY1) begin
            key1_nx[BLK_W-1:WORD_W] = pwdata;
            key_valid_nx            = 1'b0;
            key_state_nx            = K1_LO;
          end
        end
        K1_LO: begin
          if (mode == MODE_KEY1) begin
            key1_nx[WORD_W-1:0] = pwdata;
            key_state_nx        = K2_HI;
          end
        end
        K2_HI: begin
          if (mode == MODE_KEY2) begin
            key2_nx[BLK_W-1:WORD_W] = pwdata;
            key_state_nx            = K2_LO;
          end
        end
        K2_LO: begin
          if (mode == MODE_KEY2) begin
            key2_nx[WORD_W-1:0] = pwdata;
            key_valid_nx        = 1'b1;
            key_state_nx        = DONE;
          end
        end
        default: begin
          key_state_nx = K1_HI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_buffer_ctrl.sv
// Directed bench for des_buffer_ctrl: key load, block handshake, result
// readback, FIFO limits, soft reset and hard reset, with fixed expectations.
module tb_des_buffer_ctrl;
  import des_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode;
  logic [31:0] pwdata;
  logic [3:0]  data_in_cnt;
  logic [3:0]  data_out_cnt;
  logic [31:0] data_out;
  logic        blk_valid;
  logic        blk_ready;
  logic [63:0] blk_data;
  logic        blk_decrypt;
  logic [63:0] key1;
  logic [63:0] key2;
  logic        key_valid;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  des_buffer_ctrl #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .pwdata       (pwdata),
    .data_in_cnt  (data_in_cnt),
    .data_out_cnt (data_out_cnt),
    .data_out     (data_out),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .blk_decrypt  (blk_decrypt),
    .key1         (key1),
    .key2         (key2),
    .key_valid    (key_valid),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] m, input logic [31:0] d);
    mode   = m;
    pwdata = d;
    tick();
    mode   = MODE_IDLE;
  endtask

  task automatic push_result(input logic [63:0] r);
    res_valid = 1'b1;
    res_data  = r;
    tick();
    res_valid = 1'b0;
  endtask

  localparam logic [63:0] R0 = 64'hC000_0001_C000_0002;
  localparam logic [63:0] R1 = 64'hC100_0001_C100_0002;
  localparam logic [63:0] R2 = 64'hC200_0001_C200_0002;
  localparam logic [63:0] R3 = 64'hC300_0001_C300_0002;
  localparam logic [63:0] R4 = 64'hC400_0001_C400_0002;

  initial begin
    rst       = 1'b1;
    mode      = MODE_IDLE;
    pwdata    = '0;
    blk_ready = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    tick();
    tick();

    // Reset values while rst is held
    check("rst_in_cnt",    64'(data_in_cnt),  64'd0);
    check("rst_out_cnt",   64'(data_out_cnt), 64'd0);
    check("rst_key1",      key1,              64'd0);
    check("rst_key_valid", 64'(key_valid),    64'd0);
    check("rst_blk_valid", 64'(blk_valid),    64'd0);
    check("rst_res_ready", 64'(res_ready),    64'd1);
    check("rst_data_out",  64'(data_out),     64'd0);
    rst = 1'b0;

    // Out-of-order key2 word before any key1 word is ignored
    cmd(MODE_KEY2, 32'hDEAD_BEEF);
    check("key2_ooo_ignored", key2, 64'd0);

    // Nine writes without keys: FIFO fills at 8, ninth dropped, no block offered
    for (int i = 0; i < 9; i++) cmd(MODE_WR_ENC, 32'h1000_0000 + 32'(i));
    check("full_in_cnt",    64'(data_in_cnt), 64'd8);
    check("full_blk_valid", 64'(blk_valid),   64'd0);

    // Key load: key_valid rises one cycle after the fourth word
    cmd(MODE_KEY1, 32'h0123_4567);
    cmd(MODE_KEY1, 32'h89AB_CDEF);
    cmd(MODE_KEY2, 32'hFEDC_BA98);
    check("key_valid_before", 64'(key_valid), 64'd0);
    cmd(MODE_KEY2, 32'h7654_3210);
    check("key1",      key1,            64'h0123_4567_89AB_CDEF);
    check("key2",      key2,            64'hFEDC_BA98_7654_3210);
    check("key_valid", 64'(key_valid),  64'd1);
    check("blk_valid_keys",  64'(blk_valid),   64'd1);
    check("blk_decrypt_enc", 64'(blk_decrypt), 64'd0);

    // Drain four blocks; the last is words 6,7 (word 8 never stored)
    blk_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("drain_blk%0d", j), blk_data,
            {32'h1000_0000 + 32'(2*j), 32'h1000_0000 + 32'(2*j + 1)});
      tick();
    end
    blk_ready = 1'b0;
    check("drain_in_cnt",    64'(data_in_cnt), 64'd0);
    check("drain_blk_valid", 64'(blk_valid),   64'd0);

    // Decrypt block held while core is not ready
    cmd(MODE_WR_DEC, 32'h1111_1111);
    check("one_word_no_blk", 64'(blk_valid), 64'd0);
    cmd(MODE_WR_DEC, 32'h2222_2222);
    for (int j = 0; j < 3; j++) begin
      check("hold_blk_valid",   64'(blk_valid),   64'd1);
      check("hold_blk_data",    blk_data,         64'h1111_1111_2222_2222);
      check("hold_blk_decrypt", 64'(blk_decrypt), 64'd1);
      check("hold_in_cnt",      64'(data_in_cnt), 64'd2);
      tick();
    end
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    check("accept_in_cnt", 64'(data_in_cnt), 64'd0);

    // Same-cycle push and 2-word pop: 3 + 1 - 2 = 2
    for (int i = 1; i <= 3; i++) cmd(MODE_WR_ENC, 32'h3333_0000 + 32'(i));
    mode      = MODE_WR_ENC;
    pwdata    = 32'h3333_0004;
    blk_ready = 1'b1;
    tick();
    mode      = MODE_IDLE;
    blk_ready = 1'b0;
    check("pushpop_in_cnt", 64'(data_in_cnt), 64'd2);
    check("pushpop_blk",    blk_data,         64'h3333_0003_3333_0004);
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    check("pushpop_drain", 64'(data_in_cnt), 64'd0);

    // One result read back as two words
    res_valid = 1'b1;
    res_data  = 64'hAAAA_AAAA_5555_5555;
    check("res_ready_empty", 64'(res_ready), 64'd1);
    tick();
    res_valid = 1'b0;
    check("rd_cnt2",   64'(data_out_cnt), 64'd2);
    check("rd_word0",  64'(data_out),     64'hAAAA_AAAA);
    mode = MODE_RD_POP;
    tick();
    check("rd_cnt1",   64'(data_out_cnt), 64'd1);
    check("rd_word1",  64'(data_out),     64'h5555_5555);
    tick();
    check("rd_cnt0",   64'(data_out_cnt), 64'd0);
    check("rd_empty",  64'(data_out),     64'd0);
    tick();
    mode = MODE_IDLE;
    check("rd_empty_pop", 64'(data_out_cnt), 64'd0);

    // Fill output FIFO to 7 (pointers wrap), then result with same-cycle pop
    push_result(R0);
    push_result(R1);
    check("res_ready_at6", 64'(res_ready), 64'd1);
    push_result(R2);
    cmd(MODE_RD_POP, 32'd0);
    push_result(R3);
    check("out_cnt7",        64'(data_out_cnt), 64'd7);
    check("res_ready_7_idle", 64'(res_ready),   64'd0);
    check("out_head_r0lo",   64'(data_out),     64'hC000_0002);
    mode      = MODE_RD_POP;
    res_valid = 1'b1;
    res_data  = R4;
    #1;
    check("res_ready_7_pop", 64'(res_ready), 64'd1);
    tick();
    mode      = MODE_IDLE;
    res_valid = 1'b0;
    check("out_cnt8",      64'(data_out_cnt), 64'd8);
    check("out_head_r1hi", 64'(data_out),     64'hC100_0001);
    check("res_ready_8",   64'(res_ready),    64'd0);
    cmd(MODE_SOFT_RST, 32'd0);
    check("soft_out_clear", 64'(data_out_cnt), 64'd0);

    // Soft reset in K2_LO with words buffered
    for (int i = 0; i < 4; i++) cmd(MODE_WR_ENC, 32'h4444_0000 + 32'(i));
    cmd(MODE_KEY1, 32'h5000_0001);
    cmd(MODE_KEY1, 32'h5000_0002);
    cmd(MODE_KEY2, 32'h5000_0003);
    push_result(R0);
    check("pre_soft_in",  64'(data_in_cnt),  64'd4);
    check("pre_soft_out", 64'(data_out_cnt), 64'd2);
    cmd(MODE_SOFT_RST, 32'd0);
    check("soft_in_cnt",    64'(data_in_cnt),  64'd0);
    check("soft_out_cnt",   64'(data_out_cnt), 64'd0);
    check("soft_key_valid", 64'(key_valid),    64'd0);
    check("soft_key1",      key1,              64'd0);
    check("soft_key2",      key2,              64'd0);
    cmd(MODE_KEY2, 32'h6000_0000);
    check("soft_k2_ignored", key2, 64'd0);
    cmd(MODE_KEY1, 32'h7000_0001);
    check("soft_k1_accepted", key1, 64'h7000_0001_0000_0000);

    // Hard reset mid-handshake beats the pop and a same-cycle write
    cmd(MODE_KEY1, 32'h7000_0002);
    cmd(MODE_KEY2, 32'h7000_0003);
    cmd(MODE_KEY2, 32'h7000_0004);
    cmd(MODE_WR_DEC, 32'h8000_0001);
    cmd(MODE_WR_DEC, 32'h8000_0002);
    check("hs_key1",      key1,            64'h7000_0001_7000_0002);
    check("hs_blk_valid", 64'(blk_valid),  64'd1);
    blk_ready = 1'b1;
    mode      = MODE_WR_ENC;
    pwdata    = 32'h8000_0003;
    rst       = 1'b1;
    #1;
    check("hs_rst_blk_valid", 64'(blk_valid), 64'd0);
    tick();
    rst       = 1'b0;
    blk_ready = 1'b0;
    mode      = MODE_IDLE;
    check("hs_rst_in_cnt",    64'(data_in_cnt), 64'd0);
    check("hs_rst_key_valid", 64'(key_valid),   64'd0);
    check("hs_rst_key1",      key1,             64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_buffer_ctrl.md
DES_BUFFER_CTRL -- requirements
Module: des_buffer_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, the word capacity of each FIFO; it SHALL be even and no greater than 8, so counts fit in 4 bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port mode, input, 3 bits: command from the APB front end (0 idle, 1 write-encrypt, 2 write-decrypt, 3 key1 word, 4 key2 word, 5 soft reset, 6 read-pop); each command lasts one cycle.
REQ-005 SHALL have port pwdata, input, 32 bits: write word, sampled in any cycle where mode is 1, 2, 3 or 4.
REQ-006 SHALL have port data_in_cnt, output, 4 bits: input FIFO occupancy in words.
REQ-007 SHALL have port data_out_cnt, output, 4 bits: output FIFO occupancy in words.
REQ-008 SHALL have port data_out, output, 32 bits: output FIFO head word, combinational; 0 when the FIFO is empty.
REQ-009 SHALL have ports blk_valid (output, 1), blk_ready (input, 1), blk_data (output, 64) and blk_decrypt (output, 1): the block handshake to the DES core.
REQ-010 SHALL have ports key1 and key2 (outputs, 64 each) and key_valid (output, 1): the 2-key 3DES keys.
REQ-011 SHALL have ports res_valid (input, 1), res_ready (output, 1) and res_data (input, 64): the result handshake from the DES core.

Function
REQ-012 SHALL, on mode 1 or 2 with data_in_cnt < DEPTH, push {pwdata, mode==2} into the input FIFO; when the FIFO is full the write SHALL be dropped and no state SHALL change.
REQ-013 SHALL assert blk_valid when data_in_cnt >= 2 and key_valid=1; blk_data SHALL be {oldest word, next word} and blk_decrypt SHALL be the direction flag of the oldest word.
REQ-014 SHALL pop two input words in any cycle where blk_valid and blk_ready are both 1; blk_data SHALL be held stable while blk_valid=1 and blk_ready=0.
REQ-015 SHALL, when a push and a 2-word pop occur in the same cycle, set data_in_cnt to count+1-2.
REQ-016 SHALL run a key-load state machine with states K1_HI, K1_LO, K2_HI, K2_LO, DONE; reset state is K1_HI.
REQ-017 SHALL, on mode 3 in K1_HI, load key1[63:32], clear key_valid and move to K1_LO; on mode 3 in K1_LO, load key1[31:0] and move to K2_HI.
REQ-018 SHALL, on mode 4 in K2_HI, load key2[63:32] and move to K2_LO; on mode 4 in K2_LO, load key2[31:0], set key_valid=1 the next cycle and move to DONE.
REQ-019 SHALL ignore out-of-order key commands (mode 4 in K1_*, mode 3 in K2_*); mode 3 in DONE SHALL behave as in K1_HI.
REQ-020 SHALL drive res_ready=1 iff data_out_cnt <= DEPTH-2, counting any same-cycle pop.
REQ-021 SHALL, on res_valid and res_ready, push res_data[63:32] followed by res_data[31:0] into the output FIFO in one cycle.
REQ-022 SHALL, on mode 6 with data_out_cnt > 0, pop one output word at the clock edge; data_out SHALL present that word during the same cycle; mode 6 on an empty FIFO SHALL have no effect.
REQ-023 SHALL, when a 2-word push and a pop occur in the same cycle, set data_out_cnt to count+2-1.
REQ-024 SHALL, on mode 5, clear both FIFOs, key1, key2, key_valid and the key state machine (to K1_HI) at the next edge, discarding any same-cycle push, pop or result.
REQ-025 SHALL wrap FIFO pointers modulo DEPTH.

Reset
REQ-026 SHALL, while rst=1, set both counts to 0, both pointers to 0, key1=0, key2=0, key_valid=0, blk_valid=0, res_ready=1, data_out=0 and the key state machine to K1_HI.
REQ-027 SHALL give rst priority over every mode command, including a reset asserted mid-handshake.

Structure
REQ-028 SHALL take the mode encodings, DEPTH default and key-state enum from shared package des_pkg.
REQ-029 SHALL instantiate sub-module word_fifo (32-bit data, DEPTH entries, push 0-2 and pop 0-2 words per cycle, with count output) twice; the input FIFO SHALL carry an extra direction bit.

Verification
REQ-030 SHALL check: keys 3,3,4,4 with words A,B,C,D -> key1={A,B}, key2={C,D}, key_valid=1 one cycle after the 4th word.
REQ-031 SHALL check: mode 2 writes 0x11111111 then 0x22222222 with blk_ready=0 for 3 cycles -> blk_valid held, blk_data=0x1111111122222222, blk_decrypt=1, data_in_cnt=2 until accepted, then 0.
REQ-032 SHALL check: 9 mode-1 writes with no keys loaded -> data_in_cnt=8 and the 9th word is dropped.
REQ-033 SHALL check: a result of 0xAAAAAAAA55555555 followed by mode 6 twice -> data_out reads 0xAAAAAAAA then 0x55555555, and data_out_cnt goes 2, 1, 0.
REQ-034 SHALL check: out count 7 with a same-cycle mode 6 -> res_ready=1, and a result accepted that cycle -> data_out_cnt=8.
REQ-035 SHALL check: mode 5 while in K2_LO with 4 words buffered -> both counts 0, key_valid=0, and the next key1 load is accepted.
